axi_traffic_gen: RTL and testbench

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

---
 rtl/axi_traffic_gen.sv | 195 +++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 traffic generator: writes an INCR burst of seed+beat words, reads it
// back, and counts beat/response mismatches against the expected pattern.
package axi_tg_pkg;

    typedef struct packed {
        logic        awvalid;
        logic [3:0]  awid;
        logic [15:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
        logic        arvalid;
        logic [3:0]  arid;
        logic [15:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [3:0]  bid;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_miso_t;

endpackage

module axi_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter logic [3:0]  ID      = 4'd0,
    parameter logic [15:0] MAX_ERR = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [31:0] seed_i,
    output axi_mosi_t   m_axi_o,
    input  axi_miso_t   m_axi_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  beat_q, beat_d;
    logic        error_q, error_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [31:0] exp_data;
    logic        last_beat;
    logic        err_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            beat_q    <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            beat_q    <= beat_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign exp_data  = seed_q + {24'd0, beat_q};
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        seed_d    = seed_q;
        beat_d    = beat_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        err_inc   = 1'b0;

        // Payload is driven from captured registers so it stays stable
        // for as long as the matching VALID is held.
        m_axi_o         = '0;
        m_axi_o.awid    = ID;
        m_axi_o.awaddr  = addr_q;
        m_axi_o.awlen   = len_q;
        m_axi_o.awsize  = 3'b010;
        m_axi_o.awburst = 2'b01;
        m_axi_o.wdata   = exp_data;
        m_axi_o.wstrb   = 4'hF;
        m_axi_o.wlast   = last_beat;
        m_axi_o.arid    = ID;
        m_axi_o.araddr  = addr_q;
        m_axi_o.arlen   = len_q;
        m_axi_o.arsize  = 3'b010;
        m_axi_o.arburst = 2'b01;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_AW;
                    addr_d  = addr_i;
                    len_d   = len_i;
                    seed_d  = seed_i;
                    beat_d  = '0;
                    error_d = 1'b0;
                end
            end
            S_AW: begin
                m_axi_o.awvalid = 1'b1;
                if (m_axi_i.awready) state_d = S_W;
            end
            S_W: begin
                m_axi_o.wvalid = 1'b1;
                if (m_axi_i.wready) begin
                    if (last_beat) state_d = S_B;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            S_B: begin
                m_axi_o.bready = 1'b1;
                if (m_axi_i.bvalid) begin
                    state_d = S_AR;
                    err_inc = (m_axi_i.bid != ID);
                end
            end
            S_AR: begin
                m_axi_o.arvalid = 1'b1;
                beat_d          = '0;
                if (m_axi_i.arready) state_d = S_R;
            end
            S_R: begin
                m_axi_o.rready = 1'b1;
                if (m_axi_i.rvalid) begin
                    err_inc = (m_axi_i.rdata != exp_data) ||
                              (m_axi_i.rid != ID) ||
                              (m_axi_i.rlast != last_beat);
                    if (last_beat) state_d = S_DONE;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_inc) begin
            error_d = 1'b1;
            if (err_cnt_q < MAX_ERR) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = error_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen: behavioural AXI RAM slave with
// programmable stalls and fault injection, one task per scenario.
module tb_axi_traffic_gen;
    import axi_tg_pkg::*;

    localparam logic [3:0] TB_ID = 4'h3;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [15:0] addr_i;
    logic [7:0]  len_i;
    logic [31:0] seed_i;
    axi_mosi_t   m;
    axi_miso_t   s;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] err_count_o;

    int tests_run;
    int tests_failed;
    int done_cnt;

    // slave knobs and logs
    int          delay;
    int          corrupt_beat;
    logic [3:0]  bid_off;
    logic [31:0] mem [0:255];
    logic [31:0] wlog [0:15];
    logic        wlast_log [0:15];
    int          wcnt;
    int          stab_bad;
    logic [32:0] aw_log;
    logic [32:0] ar_log;
    logic [3:0]  wstrb_log;

    axi_traffic_gen #(.ID(TB_ID), .MAX_ERR(16'd2)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .addr_i     (addr_i),
        .len_i      (len_i),
        .seed_i     (seed_i),
        .m_axi_o    (m),
        .m_axi_i    (s),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .err_count_o(err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        done_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done_o) done_cnt++;
        end
    end

    // AXI RAM slave: decisions made on the falling edge, taken at the next rising edge
    initial begin
        int aw_wait, w_wait, ar_wait, b_wait, r_wait, r_left, r_beat;
        logic b_pend, prev_bready, prev_rready, w_cap_last;
        logic [15:0] aw_snap, ar_snap;
        logic [32:0] w_snap;
        logic [7:0] w_base, r_base, r_len, idx;
        s = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        r_left = 0; r_beat = 0; b_pend = 0; prev_bready = 0; prev_rready = 0;
        w_cap_last = 0; w_base = 0; r_base = 0; r_len = 0;
        aw_snap = 0; ar_snap = 0; w_snap = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                s = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                r_left = 0; r_beat = 0; b_pend = 0;
                prev_bready = 0; prev_rready = 0;
            end else begin
                if (s.awready) begin
                    s.awready = 0; aw_wait = 0;
                end else if (m.awvalid) begin
                    if (aw_wait == 0) aw_snap = m.awaddr;
                    else if (m.awaddr !== aw_snap) stab_bad++;
                    if (aw_wait >= delay) begin
                        s.awready = 1;
                        aw_log = {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst};
                        w_base = m.awaddr[9:2];
                    end else aw_wait++;
                end else if (aw_wait > 0) stab_bad++;

                if (s.wready) begin
                    s.wready = 0; w_wait = 0;
                    if (w_cap_last) b_pend = 1;
                end
                if (m.wvalid) begin
                    if (w_wait == 0) w_snap = {m.wdata, m.wlast};
                    else if ({m.wdata, m.wlast} !== w_snap) stab_bad++;
                    if (w_wait >= delay) begin
                        s.wready = 1;
                        if (wcnt < 16) begin
                            wlog[wcnt] = m.wdata;
                            wlast_log[wcnt] = m.wlast;
                        end
                        idx = w_base + wcnt[7:0];
                        mem[idx] = m.wdata;
                        wstrb_log = m.wstrb;
                        w_cap_last = m.wlast;
                        wcnt++;
                    end else w_wait++;
                end else if (w_wait > 0) stab_bad++;

                if (s.bvalid && prev_bready) begin
                    s.bvalid = 0; b_pend = 0; b_wait = 0;
                end
                if (b_pend && !s.bvalid) begin
                    if (b_wait >= delay) begin
                        s.bvalid = 1;
                        s.bid = TB_ID + bid_off;
                    end else b_wait++;
                end

                if (s.arready) begin
                    s.arready = 0; ar_wait = 0;
                    r_left = int'(r_len) + 1; r_beat = 0; r_wait = 0;
                end else if (m.arvalid) begin
                    if (ar_wait == 0) ar_snap = m.araddr;
                    else if (m.araddr !== ar_snap) stab_bad++;
                    if (ar_wait >= delay) begin
                        s.arready = 1;
                        ar_log = {m.arid, m.araddr, m.arlen, m.arsize, m.arburst};
                        r_base = m.araddr[9:2];
                        r_len = m.arlen;
                    end else ar_wait++;
                end else if (ar_wait > 0) stab_bad++;

                if (s.rvalid && prev_rready) begin
                    s.rvalid = 0; r_beat++; r_left--; r_wait = 0;
                end
                if (r_left > 0 && !s.rvalid) begin
                    if (r_wait >= delay) begin
                        idx = r_base + r_beat[7:0];
                        s.rvalid = 1;
                        s.rid = TB_ID;
                        s.rdata = mem[idx] ^ ((r_beat == corrupt_beat) ? 32'h1 : 32'h0);
                        s.rlast = (r_left == 1);
                    end else r_wait++;
                end
                prev_bready = m.bready;
                prev_rready = m.rready;
            end
        end
    end

    task automatic run_burst(input logic [15:0] a, input logic [7:0] l,
                             input logic [31:0] sd, output bit ok,
                             output logic err0);
        @(negedge clk);
        wcnt = 0; stab_bad = 0;
        addr_i = a; len_i = l; seed_i = sd; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        err0 = error_o;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_o) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready});
        end
        tests_run++;
        if ({busy_o, done_o, error_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_status: got %b want 000", {busy_o, done_o, error_o});
        end
        tests_run++;
        if (err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_errcnt: got %0d want 0", err_count_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({m.awvalid, m.wvalid, m.arvalid, busy_o} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b want 0000",
                     {m.awvalid, m.wvalid, m.arvalid, busy_o});
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic e0;
        int dc;
        delay = 0; corrupt_beat = -1; bid_off = 0;
        dc = done_cnt;
        run_burst(16'h0010, 8'd3, 32'hA5A50000, ok, e0);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic_done: got timeout want done_o");
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (wlog[i] !== 32'hA5A50000 + i || mem[4 + i] !== 32'hA5A50000 + i) begin
                tests_failed++;
                $display("FAIL basic_wdata[%0d]: got %h/%h want %h", i, wlog[i],
                         mem[4 + i], 32'hA5A50000 + i);
            end
        end
        tests_run++;
        if (aw_log !== {TB_ID, 16'h0010, 8'd3, 3'b010, 2'b01} || ar_log !== aw_log ||
            wstrb_log !== 4'hF) begin
            tests_failed++;
            $display("FAIL basic_addr_ch: got aw %h ar %h strb %h want %h",
                     aw_log, ar_log, wstrb_log, {TB_ID, 16'h0010, 8'd3, 3'b010, 2'b01});
        end
        tests_run++;
        if (wcnt !== 4 || wlast_log[3] !== 1'b1 || wlast_log[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_wlast: got beats %0d last %b%b want 4 10",
                     wcnt, wlast_log[3], wlast_log[2]);
        end
        tests_run++;
        if (done_cnt - dc !== 1 || error_o !== 1'b0 || err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL basic_status: got done %0d err %b cnt %0d want 1 0 0",
                     done_cnt - dc, error_o, err_count_o);
        end
    endtask

    task automatic test_len0_stall();
        bit ok;
        logic e0;
        int dc;
        delay = 5; corrupt_beat = -1; bid_off = 0;
        dc = done_cnt;
        run_burst(16'h0100, 8'd0, 32'h5EED0001, ok, e0);
        repeat (5) @(negedge clk);
        tests_run++;
        if (!ok || done_cnt - dc !== 1) begin
            tests_failed++;
            $display("FAIL stall_done: got ok %0d pulses %0d want 1 1", ok, done_cnt - dc);
        end
        tests_run++;
        if (stab_bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d violations want 0", stab_bad);
        end
        tests_run++;
        if (wcnt !== 1 || wlast_log[0] !== 1'b1 || wlog[0] !== 32'h5EED0001) begin
            tests_failed++;
            $display("FAIL stall_wlast: got beats %0d last %b data %h want 1 1 5eed0001",
                     wcnt, wlast_log[0], wlog[0]);
        end
        tests_run++;
        if (error_o !== 1'b0 || err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL stall_err: got %b %0d want 0 0", error_o, err_count_o);
        end
        delay = 0;
    endtask

    task automatic test_rdata_corrupt();
        bit ok;
        logic e0;
        delay = 0; corrupt_beat = 2; bid_off = 0;
        run_burst(16'h0200, 8'd3, 32'h0000C000, ok, e0);
        repeat (5) @(negedge clk);
        tests_run++;
        if (!ok || err_count_o !== 16'd1 || error_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL corrupt_count: got ok %0d cnt %0d err %b want 1 1 1",
                     ok, err_count_o, error_o);
        end
        corrupt_beat = -1;
    endtask

    task automatic test_bid_err();
        bit ok;
        logic e0;
        int dc;
        delay = 0; corrupt_beat = -1; bid_off = 4'd1;
        dc = done_cnt;
        run_burst(16'h0300, 8'd1, 32'h11110000, ok, e0);
        tests_run++;
        if (e0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sticky_clear: got error_o %b after start want 0", e0);
        end
        tests_run++;
        if (!ok || done_cnt - dc !== 1 || err_count_o !== 16'd2 || error_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bid_err: got ok %0d done %0d cnt %0d err %b want 1 1 2 1",
                     ok, done_cnt - dc, err_count_o, error_o);
        end
        bid_off = 0;
    endtask

    task automatic test_saturate();
        bit ok;
        logic e0;
        delay = 0; corrupt_beat = 0; bid_off = 0;
        run_burst(16'h0400, 8'd1, 32'h22220000, ok, e0);
        tests_run++;
        if (!ok || err_count_o !== 16'd2 || error_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturate: got ok %0d cnt %0d err %b want 1 2 1",
                     ok, err_count_o, error_o);
        end
        corrupt_beat = -1;
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        logic e0;
        int dc;
        delay = 0; corrupt_beat = -1; bid_off = 0;
        @(negedge clk);
        addr_i = 16'h0500; len_i = 8'd3; seed_i = 32'h0BAD0000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (m.wvalid && m.wdata == 32'h0BAD0001) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL midrst_reach: got no W beat 1 want W beat 1");
        end
        dc = done_cnt;
        rst_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({m.awvalid, m.wvalid, m.arvalid, busy_o} !== 4'b0 || err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrst_state: got %b cnt %0d want 0000 0",
                     {m.awvalid, m.wvalid, m.arvalid, busy_o}, err_count_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({m.awvalid, m.wvalid, m.arvalid, busy_o} !== 4'b0) begin
            tests_failed++;
            $display("FAIL midrst_release: got %b want 0000",
                     {m.awvalid, m.wvalid, m.arvalid, busy_o});
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt !== dc) begin
            tests_failed++;
            $display("FAIL midrst_nodone: got %0d pulses want 0", done_cnt - dc);
        end
        run_burst(16'h0080, 8'd2, 32'h12345678, ok, e0);
        tests_run++;
        if (!ok || wlog[0] !== 32'h12345678 || wlog[2] !== 32'h1234567A ||
            error_o !== 1'b0 || err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL midrst_rerun: got ok %0d %h %h err %b cnt %0d want 1 12345678 1234567a 0 0",
                     ok, wlog[0], wlog[2], error_o, err_count_o);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic e0;
        delay = 0; corrupt_beat = -1; bid_off = 0;
        run_burst(16'h0040, 8'd1, 32'hFFFFFFFF, ok, e0);
        tests_run++;
        if (!ok || wcnt !== 2 || wlog[0] !== 32'hFFFFFFFF || wlog[1] !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL wrap_data: got ok %0d beats %0d %h %h want 1 2 ffffffff 00000000",
                     ok, wcnt, wlog[0], wlog[1]);
        end
        tests_run++;
        if (error_o !== 1'b0 || err_count_o !== 16'd0) begin
            tests_failed++;
            $display("FAIL wrap_err: got %b %0d want 0 0", error_o, err_count_o);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_i = 1'b1; start_i = 1'b0;
        addr_i = '0; len_i = '0; seed_i = '0;
        delay = 0; corrupt_beat = -1; bid_off = 0;
        wcnt = 0; stab_bad = 0;
        aw_log = '0; ar_log = '0; wstrb_log = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            wlog[i] = '0;
            wlast_log[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_len0_stall();
        test_rdata_corrupt();
        test_bid_err();
        test_saturate();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
